// File: rtl/address_demap.sv
// address_demap
// Memory-side inverse of the node address map. Takes one global-address
// request at a time from the NoC ejection port and decodes it into either an
// owning node {X,Y} plus a 10-bit local word offset, or a shared-bank offset.
// It then performs a single access on the memory port and returns a tagged
// response to the requester.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_*                     request channel from the NoC (valid/ready)
//   mem_*                     single-access memory port (strobes + busywait)
//   resp_*                    response channel to the NoC (valid/ready)
//
// Parameter
//   TIMEOUT                   max busy cycles in ACCESS before abort (1..255)
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | ready for a request; latch it on handshake
// S_ACCESS  | strobe held on the memory port until done or timed out
// S_RESPOND | response presented until the NoC accepts it

module address_demap #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_srcnode_i,
  input  logic [31:0] req_address_i,
  input  logic [31:0] req_writedata_i,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_shared_o,
  output logic [3:0]  mem_node_o,
  output logic [9:0]  mem_address_o,
  output logic [31:0] mem_writedata_o,
  input  logic [31:0] mem_readdata_i,
  input  logic        mem_busywait_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [3:0]  resp_destnode_o,
  output logic        resp_write_o,
  output logic [31:0] resp_data_o,
  output logic        resp_error_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [3:0]  src_q, src_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  cnt_inc;
  logic        req_legal;
  logic        addr_shared;

  // Node region is 0x0000-0x3FFF; shared bank is 0x4000-0x41FF, i.e. the
  // 512-word page whose upper bits A[31:9] equal 0x20.
  function automatic logic is_node(input logic [31:0] a);
    return (a[31:14] == 18'd0);
  endfunction

  function automatic logic is_shared(input logic [31:0] a);
    return (a[31:9] == 23'h000020);
  endfunction

  assign cnt_inc     = cnt_q + 8'd1;
  assign req_legal   = is_node(req_address_i) | is_shared(req_address_i);
  assign addr_shared = is_shared(addr_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      src_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    src_d   = src_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          src_d   = req_srcnode_i;
          addr_d  = req_address_i;
          wdata_d = req_writedata_i;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          if (req_legal) begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESPOND;
          end
        end
      end
      S_ACCESS: begin
        if (!mem_busywait_i) begin
          rdata_d = write_q ? 32'd0 : mem_readdata_i;
          err_d   = 1'b0;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_inc;
          // Abort on the edge that brings the busy count up to TIMEOUT, so
          // the strobe stays high for exactly TIMEOUT cycles.
          if (cnt_inc == TimeoutCnt) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; everything is forced to 0 while reset is asserted so the
  // memory port and NoC see a quiet block even before the reset edge.
  always_comb begin
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_shared_o    = 1'b0;
    mem_node_o      = 4'd0;
    mem_address_o   = 10'd0;
    mem_writedata_o = 32'd0;
    resp_destnode_o = 4'd0;
    resp_write_o    = 1'b0;
    resp_data_o     = 32'd0;
    resp_error_o    = 1'b0;

    if (!reset_i) begin
      req_ready_o  = (state_q == S_IDLE);
      resp_valid_o = (state_q == S_RESPOND);

      if (state_q == S_ACCESS) begin
        mem_read_o      = ~write_q;
        mem_write_o     = write_q;
        mem_shared_o    = addr_shared;
        mem_node_o      = addr_shared ? 4'd0 : addr_q[13:10];
        mem_address_o   = addr_shared ? {1'b0, addr_q[8:0]} : addr_q[9:0];
        mem_writedata_o = wdata_q;
      end

      if (state_q == S_RESPOND) begin
        resp_destnode_o = src_q;
        resp_write_o    = write_q;
        resp_data_o     = rdata_q;
        resp_error_o    = err_q;
      end
    end
  end

endmodule

// File: tb/tb_address_demap.sv
// tb_address_demap
// Self-checking bench for address_demap. Directed cases from the test plan
// followed by randomized transactions, each checked against a transaction
// level model of the address map, wait-state latency and timeout rules.

module tb_address_demap;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_srcnode;
  logic [31:0] req_address, req_writedata;
  logic        mem_read, mem_write, mem_shared;
  logic [3:0]  mem_node;
  logic [9:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_destnode;
  logic        resp_write;
  logic [31:0] resp_data;
  logic        resp_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        write;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  logic [31:0] edge_addrs [8];

  address_demap #(.TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_srcnode_i   (req_srcnode),
    .req_address_i   (req_address),
    .req_writedata_i (req_writedata),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_shared_o    (mem_shared),
    .mem_node_o      (mem_node),
    .mem_address_o   (mem_address),
    .mem_writedata_o (mem_writedata),
    .mem_readdata_i  (mem_readdata),
    .mem_busywait_i  (mem_busywait),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_destnode_o (resp_destnode),
    .resp_write_o    (resp_write),
    .resp_data_o     (resp_data),
    .resp_error_o    (resp_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference address map.
  function automatic bit m_legal(input logic [31:0] a);
    return a < 32'h4200;
  endfunction

  function automatic bit m_shared(input logic [31:0] a);
    return (a >= 32'h4000) && (a < 32'h4200);
  endfunction

  function automatic logic [31:0] m_node(input logic [31:0] a);
    return m_shared(a) ? 32'd0 : (a / 1024);
  endfunction

  function automatic logic [31:0] m_offset(input logic [31:0] a);
    return m_shared(a) ? (a - 32'h4000) : (a % 1024);
  endfunction

  function automatic txn_t gen_txn();
    txn_t t;
    t.write = 1'($urandom_range(0, 1));
    t.src   = 4'($urandom_range(0, 15));
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.waits = $urandom_range(0, 5);
    case ($urandom_range(0, 3))
      0:       t.addr = $urandom & 32'h3FFF;
      1:       t.addr = 32'h4000 + $urandom_range(0, 511);
      2:       t.addr = edge_addrs[$urandom_range(0, 7)];
      default: t.addr = $urandom;
    endcase
    return t;
  endfunction

  task automatic drive_junk_req();
    req_valid     = 1'($urandom_range(0, 1));
    req_write     = 1'($urandom_range(0, 1));
    req_srcnode   = 4'($urandom_range(0, 15));
    req_address   = $urandom & 32'h3FFF;
    req_writedata = $urandom;
  endtask

  task automatic drive_req(input txn_t t);
    req_valid     = 1'b1;
    req_write     = t.write;
    req_srcnode   = t.src;
    req_address   = t.addr;
    req_writedata = t.wdata;
  endtask

  // Called at #1 after a rising edge with the block idle. Returns at #1
  // after the response handshake edge. With chain set, the next request is
  // held valid through the response phase.
  task automatic run_txn(input txn_t t, input int stall, input bit chain, input txn_t nxt);
    bit          legal, tmo;
    int          exp_strobes, exp_lat, k, strobes;
    logic [31:0] exp_data;
    bit          exp_err;

    legal       = m_legal(t.addr);
    tmo         = legal && (t.waits >= int'(TO));
    exp_strobes = !legal ? 0 : (tmo ? int'(TO) : t.waits + 1);
    exp_lat     = exp_strobes + 1;
    exp_err     = !legal || tmo;
    exp_data    = (legal && !tmo && !t.write) ? t.rdata : 32'd0;

    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    drive_req(t);
    resp_ready   = 1'($urandom_range(0, 1));
    mem_busywait = 1'($urandom_range(0, 1));
    mem_readdata = $urandom;
    @(posedge clk); #1;

    k = 1;
    strobes = 0;
    while (!resp_valid && k <= 20) begin
      if (mem_read || mem_write) strobes++;
      if (k <= exp_strobes) begin
        check_eq("mem_read", 32'(mem_read), 32'(!t.write));
        check_eq("mem_write", 32'(mem_write), 32'(t.write));
        check_eq("mem_shared", 32'(mem_shared), 32'(m_shared(t.addr)));
        check_eq("mem_node", 32'(mem_node), m_node(t.addr));
        check_eq("mem_address", 32'(mem_address), m_offset(t.addr));
        if (t.write) check_eq("mem_writedata", mem_writedata, t.wdata);
      end
      drive_junk_req();
      mem_busywait = (k <= t.waits);
      mem_readdata = (k == t.waits + 1) ? t.rdata : $urandom;
      resp_ready   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    check_eq("latency", 32'(k), 32'(exp_lat));
    check_eq("strobe_cycles", 32'(strobes), 32'(exp_strobes));

    for (int s = 0; s <= stall; s++) begin
      check_eq("resp_valid", 32'(resp_valid), 32'd1);
      check_eq("resp_destnode", 32'(resp_destnode), 32'(t.src));
      check_eq("resp_write", 32'(resp_write), 32'(t.write));
      check_eq("resp_data", resp_data, exp_data);
      check_eq("resp_error", 32'(resp_error), 32'(exp_err));
      check_eq("req_ready_busy", 32'(req_ready), 32'd0);
      check_eq("strobe_in_resp", 32'(mem_read | mem_write), 32'd0);
      mem_busywait = 1'($urandom_range(0, 1));
      if (chain) drive_req(nxt);
      else if (s < stall) drive_junk_req();
      else req_valid = 1'b0;
      resp_ready = (s == stall);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    check_eq("resp_valid_after_hs", 32'(resp_valid), 32'd0);
  endtask

  txn_t cur, nxt, a, b;

  initial begin
    edge_addrs[0] = 32'h0000_0000;
    edge_addrs[1] = 32'h0000_3FFF;
    edge_addrs[2] = 32'h0000_4000;
    edge_addrs[3] = 32'h0000_41FF;
    edge_addrs[4] = 32'h0000_4200;
    edge_addrs[5] = 32'hFFFF_FFFF;
    edge_addrs[6] = 32'hFFFF_FFFC;
    edge_addrs[7] = 32'h8000_0000;

    reset         = 1'b1;
    req_valid     = 1'b1;
    req_write     = 1'b0;
    req_srcnode   = 4'h5;
    req_address   = 32'h0000_0100;
    req_writedata = 32'd0;
    mem_readdata  = 32'd0;
    mem_busywait  = 1'b0;
    resp_ready    = 1'b0;

    // Reset, with a legal request presented that must not be taken.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_strobes", 32'(mem_read | mem_write), 32'd0);
    check_eq("rst_mem_address", 32'(mem_address), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_no_access", 32'(mem_read | mem_write), 32'd0);

    // Node read, zero wait.
    cur = '{write: 1'b0, src: 4'h3, addr: 32'h2405, wdata: 32'd0, rdata: 32'hDEADBEEF, waits: 0};
    run_txn(cur, 0, 1'b0, cur);
    // Shared write, three wait cycles.
    cur = '{write: 1'b1, src: 4'hA, addr: 32'h4123, wdata: 32'h12345678, rdata: 32'h0BAD0BAD, waits: 3};
    run_txn(cur, 1, 1'b0, cur);
    // Illegal addresses.
    cur = '{write: 1'b0, src: 4'h1, addr: 32'h4200, wdata: 32'd0, rdata: 32'h11111111, waits: 0};
    run_txn(cur, 0, 1'b0, cur);
    cur = '{write: 1'b1, src: 4'h2, addr: 32'hFFFFFFFC, wdata: 32'h5A5A5A5A, rdata: 32'h22222222, waits: 0};
    run_txn(cur, 2, 1'b0, cur);
    // Timeout with busywait stuck high.
    cur = '{write: 1'b0, src: 4'h7, addr: 32'h0123, wdata: 32'd0, rdata: 32'h33333333, waits: 50};
    run_txn(cur, 0, 1'b0, cur);
    // Backpressure with a second request waiting.
    a = '{write: 1'b0, src: 4'hC, addr: 32'h3FFF, wdata: 32'd0, rdata: 32'hCAFEF00D, waits: 1};
    b = '{write: 1'b1, src: 4'hD, addr: 32'h41FF, wdata: 32'hA5A5A5A5, rdata: 32'd0, waits: 0};
    run_txn(a, 5, 1'b1, b);
    run_txn(b, 0, 1'b0, b);

    // Reset in the middle of a waited read.
    req_valid = 1'b1; req_write = 1'b0; req_srcnode = 4'h6; req_address = 32'h0200;
    @(posedge clk); #1;
    check_eq("rstmid_read_c1", 32'(mem_read), 32'd1);
    req_valid = 1'b0; mem_busywait = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_read_c2", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstmid_strobe_gated", 32'(mem_read | mem_write), 32'd0);
    @(posedge clk); #1;
    check_eq("rstmid_strobes", 32'(mem_read | mem_write), 32'd0);
    check_eq("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rstmid_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0; mem_busywait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("rstmid_idle_ready", 32'(req_ready), 32'd1);
      check_eq("rstmid_no_resp", 32'(resp_valid), 32'd0);
      check_eq("rstmid_no_strobe", 32'(mem_read | mem_write), 32'd0);
    end

    // Randomized traffic, occasionally chaining back-to-back requests.
    cur = gen_txn();
    for (int i = 0; i < 60; i++) begin
      nxt = gen_txn();
      run_txn(cur, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), nxt);
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
